// File: rtl/ps2_key_tracker.sv
// PS/2 scan-byte decoder: tracks held game keys and queues press/release events in a FWFT FIFO.
// Optional macro PS2_ARROW_ALIAS_EN maps extended arrow keys onto the W/A/S/D bits.
module ps2_key_tracker #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    scan_code,
    input  logic                          scan_ready,
    output logic [5:0]                    key_status,
    output logic                          evt_valid,
    output logic [3:0]                    evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    // Returns {hit, key_index}
    function automatic logic [3:0] map_make(input logic [7:0] c);
        case (c)
            8'h1D:   map_make = 4'b1_000;
            8'h1C:   map_make = 4'b1_001;
            8'h1B:   map_make = 4'b1_010;
            8'h23:   map_make = 4'b1_011;
            8'h29:   map_make = 4'b1_100;
            8'h2D:   map_make = 4'b1_101;
            default: map_make = 4'b0_000;
        endcase
    endfunction

    logic [3:0] make_hit;
    logic [3:0] ext_hit;

    assign make_hit = map_make(scan_code);

`ifdef PS2_ARROW_ALIAS_EN
    function automatic logic [3:0] map_ext(input logic [7:0] c);
        case (c)
            8'h75:   map_ext = 4'b1_000;
            8'h6B:   map_ext = 4'b1_001;
            8'h72:   map_ext = 4'b1_010;
            8'h74:   map_ext = 4'b1_011;
            default: map_ext = 4'b0_000;
        endcase
    endfunction
    assign ext_hit = map_ext(scan_code);
`else
    assign ext_hit = 4'b0_000;
`endif

    state_t           state_q, state_d;
    logic [5:0]       key_q, key_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic       set_req, clr_req;
    logic [2:0] req_idx;
    logic       push;
    logic [3:0] push_data;
    logic       pop, full, do_push, drop;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        tmo_d     = tmo_q;
        set_req   = 1'b0;
        clr_req   = 1'b0;
        req_idx   = 3'd0;
        push      = 1'b0;
        push_data = 4'b0;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (scan_ready) begin
                case (scan_code)
                    8'hF0:   state_d = BREAK;
                    8'hE0:   state_d = EXT;
                    8'hAA:   key_d   = '0;
                    default: begin
                        set_req = make_hit[3];
                        req_idx = make_hit[2:0];
                    end
                endcase
            end
        end else if (scan_ready) begin
            tmo_d = '0;
            case (state_q)
                BREAK: begin
                    case (scan_code)
                        8'hF0:   state_d = BREAK;
                        8'hE0:   state_d = EXT;
                        default: begin
                            clr_req = make_hit[3];
                            req_idx = make_hit[2:0];
                            state_d = IDLE;
                        end
                    endcase
                end
                EXT: begin
                    case (scan_code)
                        8'hF0:   state_d = EXT_BREAK;
                        8'hE0:   state_d = EXT;
                        default: begin
                            set_req = ext_hit[3];
                            req_idx = ext_hit[2:0];
                            state_d = IDLE;
                        end
                    endcase
                end
                default: begin
                    case (scan_code)
                        8'hF0:   state_d = EXT_BREAK;
                        8'hE0:   state_d = EXT;
                        default: begin
                            clr_req = ext_hit[3];
                            req_idx = ext_hit[2:0];
                            state_d = IDLE;
                        end
                    endcase
                end
            endcase
        end else if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // Events only on real bit transitions, so typematic repeats stay silent
        if (set_req && !key_q[req_idx]) begin
            key_d[req_idx] = 1'b1;
            push           = 1'b1;
            push_data      = {1'b1, req_idx};
        end
        if (clr_req && key_q[req_idx]) begin
            key_d[req_idx] = 1'b0;
            push           = 1'b1;
            push_data      = {1'b0, req_idx};
        end
    end

    assign pop     = evt_valid & evt_ready;
    assign full    = (cnt_q == CNT_FULL);
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            tmo_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign key_status = key_q;
    assign evt_valid  = (cnt_q != '0);
    assign evt_data   = evt_valid ? mem_q[rd_q] : 4'b0;
    assign evt_count  = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus a randomized run against a behavioural model.
module tb_ps2_key_tracker;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic [5:0] key_status;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_ready;
    logic [3:0] evt_count;
    logic       overflow;
    logic       clear_overflow;

    int vectors;
    int miscompares;

    ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
        .key_status(key_status), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Spec key table; -1 means not a tracked key
    function automatic int std_key(input logic [7:0] b);
        case (b)
            8'h1D: return 0;
            8'h1C: return 1;
            8'h1B: return 2;
            8'h23: return 3;
            8'h29: return 4;
            8'h2D: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_key(input logic [7:0] b);
`ifdef PS2_ARROW_ALIAS_EN
        case (b)
            8'h75: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
`else
        return (b == 8'hFF && b != 8'hFF) ? 0 : -1;
`endif
    endfunction

    function automatic logic [7:0] pick_byte(input int sel);
        case (sel)
            0: return 8'h1D;   1: return 8'h1C;   2: return 8'h1B;   3: return 8'h23;
            4: return 8'h29;   5: return 8'h2D;   6: return 8'hF0;   7: return 8'hF0;
            8: return 8'hE0;   9: return 8'hE0;  10: return 8'hAA;  11: return 8'h75;
            12: return 8'h6B; 13: return 8'h72;  14: return 8'h74;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00;
        evt_ready = 1'b0; clear_overflow = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code = b; scan_ready = 1'b1;
        @(negedge clk);
        scan_ready = 1'b0;
    endtask

    task automatic pop_one;
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if (key_status !== 6'b0) begin miscompares++; $display("FAIL reset_key: got %b expected 000000", key_status); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        vectors++; if (evt_data !== 4'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", evt_data); end
        vectors++; if (evt_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_typematic;
        do_reset;
        send_byte(8'h1D);
        vectors++; if (key_status !== 6'b000001) begin miscompares++; $display("FAIL typ_key1: got %b expected 000001", key_status); end
        vectors++; if (evt_data !== 4'h8) begin miscompares++; $display("FAIL typ_data1: got %h expected 8", evt_data); end
        send_byte(8'h1D); send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
        vectors++; if (key_status !== 6'b000000) begin miscompares++; $display("FAIL typ_key2: got %b expected 000000", key_status); end
        vectors++; if (evt_count !== 4'd2) begin miscompares++; $display("FAIL typ_count: got %0d expected 2", evt_count); end
        vectors++; if (evt_data !== 4'h8) begin miscompares++; $display("FAIL typ_front: got %h expected 8", evt_data); end
        pop_one;
        vectors++; if (evt_data !== 4'h0 || evt_count !== 4'd1) begin miscompares++; $display("FAIL typ_second: got data %h count %0d expected data 0 count 1", evt_data, evt_count); end
        pop_one;
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL typ_empty: got valid %b expected 0", evt_valid); end
        pop_one;
        vectors++; if (evt_count !== 4'd0) begin miscompares++; $display("FAIL typ_pop_empty: got count %0d expected 0", evt_count); end
    endtask

    task automatic test_order;
        logic [3:0] exp_ord [3];
        exp_ord[0] = 4'hC; exp_ord[1] = 4'hD; exp_ord[2] = 4'h4;
        do_reset;
        send_byte(8'h29); send_byte(8'h2D); send_byte(8'hF0); send_byte(8'h29);
        vectors++; if (key_status !== 6'b100000) begin miscompares++; $display("FAIL order_key: got %b expected 100000", key_status); end
        vectors++; if (evt_count !== 4'd3) begin miscompares++; $display("FAIL order_count: got %0d expected 3", evt_count); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (evt_valid !== 1'b1 || evt_data !== exp_ord[i]) begin miscompares++; $display("FAIL order_evt%0d: got valid %b data %h expected valid 1 data %h", i, evt_valid, evt_data, exp_ord[i]); end
            pop_one;
        end
    endtask

    task automatic test_overflow;
        do_reset;
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1) send_byte(8'hF0);
            send_byte(8'h1C);
        end
        vectors++; if (evt_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d expected 8", evt_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        vectors++; if (key_status !== 6'b000010) begin miscompares++; $display("FAIL ovf_key: got %b expected 000010", key_status); end
        @(negedge clk); clear_overflow = 1'b1;
        @(negedge clk); clear_overflow = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            logic [3:0] e;
            e = (i % 2 == 0) ? 4'h9 : 4'h1;
            vectors++; if (evt_data !== e) begin miscompares++; $display("FAIL ovf_evt%0d: got %h expected %h", i, evt_data, e); end
            pop_one;
        end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got valid %b expected 0", evt_valid); end
    endtask

    task automatic test_timeout;
        do_reset;
        send_byte(8'hF0);
        repeat (3) @(negedge clk);
        send_byte(8'h1C);
        vectors++; if (key_status !== 6'b0 || evt_count !== 4'd0) begin miscompares++; $display("FAIL tmo_short: got key %b count %0d expected key 000000 count 0", key_status, evt_count); end
        send_byte(8'hF0);
        repeat (TMO + 5) @(negedge clk);
        send_byte(8'h1C);
        vectors++; if (key_status !== 6'b000010) begin miscompares++; $display("FAIL tmo_key: got %b expected 000010", key_status); end
        vectors++; if (evt_count !== 4'd1 || evt_data !== 4'h9) begin miscompares++; $display("FAIL tmo_evt: got count %0d data %h expected count 1 data 9", evt_count, evt_data); end
    endtask

    task automatic test_selftest_clear;
        do_reset;
        send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h23);
        vectors++; if (key_status !== 6'b001101) begin miscompares++; $display("FAIL aa_held: got %b expected 001101", key_status); end
        send_byte(8'hAA);
        vectors++; if (key_status !== 6'b0) begin miscompares++; $display("FAIL aa_key: got %b expected 000000", key_status); end
        vectors++; if (evt_count !== 4'd3 || evt_data !== 4'h8) begin miscompares++; $display("FAIL aa_events: got count %0d data %h expected count 3 data 8", evt_count, evt_data); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        send_byte(8'h1D);
        send_byte(8'hE0);
        #2 reset = 1'b1;
        #1;
        vectors++; if (key_status !== 6'b0 || evt_valid !== 1'b0 || evt_data !== 4'h0 || evt_count !== 4'd0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL midreset_outputs: got key %b valid %b data %h count %0d ovf %b expected all 0", key_status, evt_valid, evt_data, evt_count, overflow);
        end
        @(negedge clk); reset = 1'b0;
        send_byte(8'h1B);
        vectors++; if (key_status !== 6'b000100) begin miscompares++; $display("FAIL midreset_key: got %b expected 000100", key_status); end
        vectors++; if (evt_count !== 4'd1 || evt_data !== 4'hA) begin miscompares++; $display("FAIL midreset_evt: got count %0d data %h expected count 1 data a", evt_count, evt_data); end
    endtask

    task automatic test_arrow;
        do_reset;
        send_byte(8'hE0); send_byte(8'h75);
`ifdef PS2_ARROW_ALIAS_EN
        vectors++; if (key_status !== 6'b000001 || evt_data !== 4'h8) begin miscompares++; $display("FAIL arrow_make: got key %b data %h expected key 000001 data 8", key_status, evt_data); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        vectors++; if (key_status !== 6'b0 || evt_count !== 4'd2) begin miscompares++; $display("FAIL arrow_break: got key %b count %0d expected key 000000 count 2", key_status, evt_count); end
        pop_one;
        vectors++; if (evt_data !== 4'h0 || evt_valid !== 1'b1) begin miscompares++; $display("FAIL arrow_release: got valid %b data %h expected valid 1 data 0", evt_valid, evt_data); end
        do_reset;
        send_byte(8'h1D); send_byte(8'hE0); send_byte(8'h75);
        vectors++; if (key_status !== 6'b000001 || evt_count !== 4'd1) begin miscompares++; $display("FAIL arrow_twin_make: got key %b count %0d expected key 000001 count 1", key_status, evt_count); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        vectors++; if (key_status !== 6'b0 || evt_count !== 4'd2) begin miscompares++; $display("FAIL arrow_twin_break: got key %b count %0d expected key 000000 count 2", key_status, evt_count); end
`else
        vectors++; if (key_status !== 6'b0 || evt_count !== 4'd0) begin miscompares++; $display("FAIL arrow_make_off: got key %b count %0d expected key 000000 count 0", key_status, evt_count); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        vectors++; if (key_status !== 6'b0 || evt_count !== 4'd0) begin miscompares++; $display("FAIL arrow_break_off: got key %b count %0d expected key 000000 count 0", key_status, evt_count); end
        send_byte(8'h1C);
        vectors++; if (key_status !== 6'b000010 || evt_data !== 4'h9) begin miscompares++; $display("FAIL arrow_back_idle: got key %b data %h expected key 000010 data 9", key_status, evt_data); end
`endif
    endtask

    task automatic test_random;
        logic [5:0] m_keys;
        bit         m_ext, m_brk, m_ov;
        logic [3:0] m_q [$];
        int         idle, quiet, idx;
        logic       sr, er, clr, pushev, dropped;
        logic [7:0] b;
        logic [3:0] ev;
        do_reset;
        m_keys = '0; m_ext = 0; m_brk = 0; m_ov = 0; idle = 0; quiet = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vectors++; if (key_status !== m_keys) begin miscompares++; $display("FAIL rnd_key@%0d: got %b expected %b", cyc, key_status, m_keys); end
            vectors++; if (evt_count !== 4'(m_q.size())) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, evt_count, m_q.size()); end
            vectors++; if (evt_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, evt_valid, m_q.size() != 0); end
            vectors++; if (overflow !== m_ov) begin miscompares++; $display("FAIL rnd_ovf@%0d: got %b expected %b", cyc, overflow, m_ov); end
            if (m_q.size() != 0) begin
                vectors++; if (evt_data !== m_q[0]) begin miscompares++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, evt_data, m_q[0]); end
            end

            sr = 1'b0; b = 8'h00;
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 299) == 0) quiet = TMO + 5;
            else if (idle >= 8 || $urandom_range(0, 2) == 0) begin
                sr = 1'b1; b = pick_byte(int'($urandom_range(0, 15)));
            end
            er  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            scan_ready = sr; scan_code = b; evt_ready = er; clear_overflow = clr;

            pushev = 1'b0; ev = 4'h0; dropped = 1'b0;
            if (sr) begin
                if (idle >= TMO) begin m_ext = 0; m_brk = 0; end
                idle = 0;
                if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
                else begin
                    if (!m_ext && !m_brk && b == 8'hAA) m_keys = '0;
                    else begin
                        idx = m_ext ? ext_key(b) : std_key(b);
                        if (idx >= 0) begin
                            if (m_brk && m_keys[idx]) begin
                                m_keys[idx] = 1'b0; pushev = 1'b1; ev = {1'b0, 3'(idx)};
                            end else if (!m_brk && !m_keys[idx]) begin
                                m_keys[idx] = 1'b1; pushev = 1'b1; ev = {1'b1, 3'(idx)};
                            end
                        end
                    end
                    m_ext = 0; m_brk = 0;
                end
            end else begin
                idle++;
            end
            if (er && m_q.size() != 0) void'(m_q.pop_front());
            if (pushev) begin
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else dropped = 1'b1;
            end
            if (dropped) m_ov = 1;
            else if (clr) m_ov = 0;

            @(negedge clk);
        end
        scan_ready = 1'b0; evt_ready = 1'b0; clear_overflow = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; scan_code = 8'h00; scan_ready = 1'b0;
        evt_ready = 1'b0; clear_overflow = 1'b0;
        test_reset;
        test_typematic;
        test_order;
        test_overflow;
        test_timeout;
        test_selftest_clear;
        test_reset_mid;
        test_arrow;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
